// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage: opcodes, instruction layout,
// sequencer state encoding and datapath width.
package alu_pkg;

  localparam int DATA_W  = 19;
  localparam int NREGS   = 8;
  localparam int REG_AW  = 3;
  localparam int INSTR_W = 19;
  localparam int IMM_W   = 6;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_NOT = 3'b111;

  // Low bit position of each instruction field.
  localparam int OP_LO   = 16;
  localparam int RD_LO   = 13;
  localparam int RS1_LO  = 10;
  localparam int RS2_LO  = 7;
  localparam int ISEL_B  = 6;
  localparam int IMM_LO  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

endpackage

// File: rtl/alu_regfile.sv
// Register file: two combinational read ports, a debug read port and one
// synchronous write port; r0 is hardwired to zero.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int NREGS  = alu_pkg::NREGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1   = (raddr1   == '0) ? '0 : regs[raddr1];
  assign rdata2   = (raddr2   == '0) ? '0 : regs[raddr2];
  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle execute controller: fetches operands from the register file,
// drives an external combinational ALU, and writes the result back.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int NREGS  = alu_pkg::NREGS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [2:0]         alu_op,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic               alu_zero,
  output logic               done,
  output logic [DATA_W-1:0]  wb_data,
  output logic               zero_flag,
  input  logic [REG_AW-1:0]  dbg_addr,
  output logic [DATA_W-1:0]  dbg_data
);

  function automatic logic [DATA_W-1:0] zext_imm(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){1'b0}}, imm};
  endfunction

  state_t              state_q, state_d;
  logic [INSTR_W-1:0]  instr_p0;
  logic [DATA_W-1:0]   res_p1;
  logic                z_p1;

  logic [2:0]          f_op;
  logic [REG_AW-1:0]   f_rd, f_rs1, f_rs2;
  logic                f_isel;
  logic [IMM_W-1:0]    f_imm;
  logic [DATA_W-1:0]   rdata1, rdata2, opnd_b;

  assign f_op   = instr_p0[OP_LO +: 3];
  assign f_rd   = instr_p0[RD_LO +: REG_AW];
  assign f_rs1  = instr_p0[RS1_LO +: REG_AW];
  assign f_rs2  = instr_p0[RS2_LO +: REG_AW];
  assign f_isel = instr_p0[ISEL_B];
  assign f_imm  = instr_p0[IMM_LO +: IMM_W];
  assign opnd_b = f_isel ? zext_imm(f_imm) : rdata2;

  alu_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .raddr1   (f_rs1),
    .rdata1   (rdata1),
    .raddr2   (f_rs2),
    .rdata2   (rdata2),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (state_q == ST_WB),
    .waddr    (f_rd),
    .wdata    (res_p1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (instr_valid) state_d = ST_READ;
      ST_READ: state_d = ST_EXEC;
      ST_EXEC: state_d = ST_WB;
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_p0  <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      res_p1    <= '0;
      z_p1      <= 1'b0;
      zero_flag <= 1'b0;
    end else begin
      // p0: instruction captured on handshake
      if (state_q == ST_IDLE && instr_valid) instr_p0 <= instr;
      // ALU operand registers; held until the next READ
      if (state_q == ST_READ) begin
        alu_a  <= rdata1;
        alu_b  <= opnd_b;
        alu_op <= f_op;
      end
      // p1: ALU output captured once its inputs have settled
      if (state_q == ST_EXEC) begin
        res_p1 <= alu_result;
        z_p1   <= alu_zero;
      end
      if (state_q == ST_WB) zero_flag <= z_p1;
    end
  end

  assign instr_ready = (state_q == ST_IDLE);
  assign done        = (state_q == ST_WB);
  assign wb_data     = res_p1;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed scoreboard bench for alu_sequencer with a behavioural 19-bit ALU
// attached to its a/b/op -> result/zero interface.
module tb_alu_sequencer;

  localparam int W = 19;

  logic          clk;
  logic          rst_n;
  logic [18:0]   instr;
  logic          instr_valid;
  logic          instr_ready;
  logic [W-1:0]  alu_a, alu_b, alu_result;
  logic [2:0]    alu_op;
  logic          alu_zero;
  logic          done;
  logic [W-1:0]  wb_data;
  logic          zero_flag;
  logic [2:0]    dbg_addr;
  logic [W-1:0]  dbg_data;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [W-1:0] data;
    logic         zero;
    logic [2:0]   rd;
    logic [W-1:0] reg_val;
  } exp_t;
  exp_t sb[$];

  alu_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .done        (done),
    .wb_data     (wb_data),
    .zero_flag   (zero_flag),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  // Behavioural ALU: wraps mod 2^19, divide by zero yields 0.
  always_comb begin
    alu_result = '0;
    case (alu_op)
      3'b000: alu_result = alu_a + alu_b;
      3'b001: alu_result = alu_a - alu_b;
      3'b010: alu_result = alu_a * alu_b;
      3'b011: alu_result = (alu_b == '0) ? '0 : alu_a / alu_b;
      3'b100: alu_result = alu_a & alu_b;
      3'b101: alu_result = alu_a | alu_b;
      3'b110: alu_result = alu_a ^ alu_b;
      default: alu_result = ~alu_a;
    endcase
    alu_zero = (alu_result == '0);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [18:0] mk(input logic [2:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [2:0] rs2,
                                     input logic isel, input logic [5:0] imm);
    return {op, rd, rs1, rs2, isel, imm};
  endfunction

  task automatic push(input logic [18:0] ins, input logic [W-1:0] d, input logic z,
                      input logic [W-1:0] rv);
    exp_t e;
    e.data = d; e.zero = z; e.rd = ins[15:13]; e.reg_val = rv;
    sb.push_back(e);
  endtask

  // Waits for done counting negedges since the accept cycle, then scores it.
  task automatic wait_done(input int elapsed, input string tag);
    int lat;
    exp_t e;
    lat = elapsed;
    while (!done && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, 3);
    if (!done) begin
      check({tag, "_done"}, done, 1);
    end else if (sb.size() == 0) begin
      check({tag, "_unexpected_done"}, sb.size(), 1);
    end else begin
      e = sb.pop_front();
      check({tag, "_wb_data"}, wb_data, e.data);
      @(negedge clk);
      check({tag, "_done_pulse"}, done, 0);
      check({tag, "_zero_flag"}, zero_flag, e.zero);
      dbg_addr = e.rd;
      #1;
      check({tag, "_reg"}, dbg_data, e.reg_val);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!instr_ready && n < 12) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) check({tag, "_ready_timeout"}, instr_ready, 1);
  endtask

  task automatic run(input string tag, input logic [18:0] ins, input logic [W-1:0] d,
                     input logic z, input logic [W-1:0] rv);
    push(ins, d, z, rv);
    instr = ins;
    instr_valid = 1'b1;
    wait_ready(tag);
    @(negedge clk);
    instr_valid = 1'b0;
    wait_done(1, tag);
  endtask

  initial begin
    rst_n = 1'b0;
    instr = mk(3'b000, 3'd1, 3'd0, 3'd0, 1'b1, 6'd33);
    instr_valid = 1'b1;
    dbg_addr = 3'd0;
    repeat (3) @(negedge clk);

    // Reset state with a pending instruction that must not be consumed.
    check("rst_ready", instr_ready, 1);
    check("rst_done", done, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_zero_flag", zero_flag, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_op", alu_op, 0);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      check($sformatf("rst_reg%0d", i), dbg_data, 0);
    end
    instr_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", instr_ready, 1);

    run("add_imm",  mk(3'b000, 3'd1, 3'd0, 3'd0, 1'b1, 6'd5),  19'd5,     1'b0, 19'd5);
    run("sub_zero", mk(3'b001, 3'd2, 3'd1, 3'd1, 1'b0, 6'd0),  19'd0,     1'b1, 19'd0);
    run("or_imm",   mk(3'b101, 3'd2, 3'd1, 3'd0, 1'b1, 6'd0),  19'd5,     1'b0, 19'd5);
    run("load63",   mk(3'b000, 3'd1, 3'd0, 3'd0, 1'b1, 6'd63), 19'd63,    1'b0, 19'd63);
    run("mul_sq",   mk(3'b010, 3'd3, 3'd1, 3'd1, 1'b0, 6'd0),  19'd3969,  1'b0, 19'd3969);
    run("mul_wrap", mk(3'b010, 3'd4, 3'd3, 3'd3, 1'b0, 6'd0),  19'd24321, 1'b0, 19'd24321);
    run("div_zero", mk(3'b011, 3'd5, 3'd1, 3'd0, 1'b0, 6'd0),  19'd0,     1'b1, 19'd0);
    run("wr_r0",    mk(3'b000, 3'd0, 3'd0, 3'd0, 1'b1, 6'd7),  19'd7,     1'b0, 19'd0);
    run("not_r0",   mk(3'b111, 3'd6, 3'd0, 3'd0, 1'b0, 6'd0),  19'h7FFFF, 1'b0, 19'h7FFFF);
    check("alu_op_held", alu_op, 3'b111);
    check("alu_a_held", alu_a, 0);
    run("and_imm",  mk(3'b100, 3'd7, 3'd4, 3'd0, 1'b1, 6'd63), 19'd1,     1'b0, 19'd1);

    // Back-to-back: valid held high, second instruction waits for IDLE.
    push(mk(3'b000, 3'd6, 3'd0, 3'd0, 1'b1, 6'd9), 19'd9, 1'b0, 19'd9);
    push(mk(3'b001, 3'd7, 3'd6, 3'd0, 1'b1, 6'd4), 19'd5, 1'b0, 19'd5);
    instr = mk(3'b000, 3'd6, 3'd0, 3'd0, 1'b1, 6'd9);
    instr_valid = 1'b1;
    wait_ready("b2b_a");
    @(negedge clk);
    instr = mk(3'b001, 3'd7, 3'd6, 3'd0, 1'b1, 6'd4);
    check("b2b_busy_ready", instr_ready, 0);
    wait_done(1, "b2b_a");
    check("b2b_second_accept", instr_ready, 1);
    @(negedge clk);
    instr_valid = 1'b0;
    wait_done(1, "b2b_b");

    // Abort during EXEC: reset must suppress writeback and done.
    instr = mk(3'b000, 3'd3, 3'd0, 3'd0, 1'b1, 6'd12);
    instr_valid = 1'b1;
    wait_ready("abort");
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_ready", instr_ready, 1);
    check("abort_done", done, 0);
    check("abort_alu_a", alu_a, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("abort_no_done%0d", i), done, 0);
    end
    dbg_addr = 3'd3;
    #1;
    check("abort_target_reg", dbg_data, 0);
    check("abort_zero_flag", zero_flag, 0);
    check("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
